// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode, func-bit and ALU encodings shared by controller, ALU and datapath.
// MCU_ILLEGAL_TRAP_EN adds the HALT state.
package mc_pkg;
    localparam int OPC_W  = 4;
    localparam int FUNC_W = 9;
    localparam int ALUC_W = 3;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMRD  = 4'd2,
        S_WBMEM  = 4'd3,
        S_MEMWR  = 4'd4,
        S_JUMP   = 4'd5,
        S_BRANCH = 4'd6,
        S_EXEC   = 4'd7,
        S_WBALU  = 4'd8
`ifdef MCU_ILLEGAL_TRAP_EN
        , S_HALT = 4'd9
`endif
    } state_t;
    localparam logic [OPC_W-1:0] OP_LDA   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_STA   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_BZ    = 4'b0100;
    localparam logic [OPC_W-1:0] OP_TYPEC = 4'b1000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_SUBI  = 4'b1101;
    localparam logic [OPC_W-1:0] OP_ANDI  = 4'b1110;
    localparam logic [OPC_W-1:0] OP_ORI   = 4'b1111;
    localparam int F_MOVETO   = 0;
    localparam int F_MOVEFROM = 1;
    localparam int F_ADD      = 2;
    localparam int F_SUB      = 3;
    localparam int F_AND      = 4;
    localparam int F_OR       = 5;
    localparam int F_NOT      = 6;
    localparam int F_NOP      = 7;
    localparam logic [ALUC_W-1:0] ALU_MOV = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b100;
    localparam logic [ALUC_W-1:0] ALU_NOT = 3'b101;
    localparam logic [ALUC_W-1:0] ALU_NOP = 3'b110;
    // the top func bit has no operation assigned, so it decodes as NOP too
    function automatic logic is_nop_func(input logic [FUNC_W-1:0] f);
        return !$onehot(f) || f[F_NOP] || f[FUNC_W-1];
    endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps controller state plus IR opcode/func to ALUControl.
module alu_op_decoder
    import mc_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] func,
    input  state_t            state,
    output logic [ALUC_W-1:0] alu_control
);
    logic [ALUC_W-1:0] imm_op, typec_op, exec_op;
    always_comb begin
        imm_op = opcode == OP_ADDI ? ALU_ADD : opcode == OP_SUBI ? ALU_SUB :
                 opcode == OP_ANDI ? ALU_AND : ALU_OR;
        // MOVETO passes R0 through as R0+0
        typec_op = func[F_MOVETO] ? ALU_ADD : func[F_MOVEFROM] ? ALU_MOV :
                   func[F_ADD] ? ALU_ADD : func[F_SUB] ? ALU_SUB :
                   func[F_AND] ? ALU_AND : func[F_OR] ? ALU_OR :
                   func[F_NOT] ? ALU_NOT : ALU_NOP;
        exec_op = opcode == OP_TYPEC ? (is_nop_func(func) ? ALU_NOP : typec_op) : imm_op;
        alu_control = state == S_FETCH ? ALU_ADD : state == S_BRANCH ? ALU_SUB :
                      state == S_EXEC ? exec_op : ALU_NOP;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the 16-bit accumulator datapath.
// MCU_ILLEGAL_TRAP_EN: illegal opcodes trap into a sticky HALT state.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic              Zero,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              PCSrc,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic              RegDst,
    output logic              MemToReg,
    output logic              halted
);
    state_t state, next;
    logic   pc_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next;
    end

    always_comb begin
        next        = S_FETCH;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        pc_write    = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
                next     = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDA:   next = S_MEMRD;
                    OP_STA:   next = S_MEMWR;
                    OP_JMP:   next = S_JUMP;
                    OP_BZ:    next = S_BRANCH;
                    OP_TYPEC: next = is_nop_func(func) ? S_FETCH : S_EXEC;
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: next = S_EXEC;
`ifdef MCU_ILLEGAL_TRAP_EN
                    default:  next = S_HALT;
`else
                    default:  next = S_FETCH;
`endif
                endcase
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = S_WBMEM;
            end
            S_WBMEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSrc    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b11;
                PCWriteCond = 1'b1;
                PCSrc       = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = opcode != OP_TYPEC ? 2'b10 : func[F_MOVETO] ? 2'b11 : 2'b00;
                next    = S_WBALU;
            end
            S_WBALU: begin
                RegWrite = 1'b1;
                RegDst   = opcode == OP_TYPEC && func[F_MOVETO];
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            S_HALT: next = S_HALT;
`endif
            default: next = S_FETCH;
        endcase
    end

    assign PCWrite = pc_write | (PCWriteCond & Zero);
`ifdef MCU_ILLEGAL_TRAP_EN
    assign halted = state == S_HALT;
`else
    assign halted = 1'b0;
`endif

    alu_op_decoder u_alu_op_decoder (
        .opcode      (opcode),
        .func        (func),
        .state       (state),
        .alu_control (ALUControl)
    );
endmodule
